// File: rtl/cnn_pkg.sv
// Shared CNN buffer definitions: bank life-cycle states and sizing helpers
// used by the ping-pong feature-map buffer and its RAM banks.
package cnn_pkg;

    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic int fmapDepth(input int ch, input int fmSize);
        return ch * fmSize * fmSize;
    endfunction

    // Width that holds 0..n-1 without truncation; never narrower than one bit.
    function automatic int cntWidth(input int n);
        if (n < 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fmap_bank_ram.sv
// One feature-map bank: simple dual-port RAM with a single-cycle registered read.
// Only the read-data register is cleared by reset; stored words persist.
module fmap_bank_ram
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output holds its last word between reads so the consumer sees stable data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fmap_pingpong_buf.sv
// Two-bank ping-pong feature-map buffer between CNN layers; a frame is read PASSES times.
// Optional ReLU clamp on store is enabled by defining FMAP_PINGPONG_BUF_RELU_EN.
module fmap_pingpong_buf
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FM_SIZE    = 13,
    parameter int CH         = 16,
    parameter int PASSES     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  layer_start,
    output logic                  frame_done
);

    localparam int DEPTH  = fmapDepth(CH, FM_SIZE);
    localparam int ADDR_W = cntWidth(DEPTH);
    localparam int PASS_W = cntWidth(PASSES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    bank_state_e            state_q [2];
    bank_state_e            state_d [2];
    logic                   wrBank_q, wrBank_d;
    logic                   rdBank_q, rdBank_d;
    logic [ADDR_W-1:0]      wrCnt_q, wrCnt_d;
    logic [ADDR_W-1:0]      rdCnt_q, rdCnt_d;
    logic [PASS_W-1:0]      pass_q, pass_d;
    logic                   rdValid_q, rdLast_q, frameDone_q, layerStart_q;
    logic                   exposed_q, rdSel_q;

    logic                   wrAccept, rdAccept, freeBank, exposedNow;
    logic [DATA_WIDTH-1:0]  storeWord;
    logic [DATA_WIDTH-1:0]  bankData0, bankData1;

    assign wr_ready   = (state_q[wrBank_q] == BANK_FREE) || (state_q[wrBank_q] == BANK_FILLING);
    assign wrAccept   = wr_en && wr_ready;
    assign rdAccept   = rd_en && ((state_q[rdBank_q] == BANK_FULL) ||
                                  (state_q[rdBank_q] == BANK_DRAINING));
    assign exposedNow = (state_q[rdBank_q] == BANK_FULL);

`ifdef FMAP_PINGPONG_BUF_RELU_EN
    assign storeWord = wr_data[DATA_WIDTH-1] ? '0 : wr_data;
`else
    assign storeWord = wr_data;
`endif

    // Writer and reader always own different banks, so both updates can apply together.
    always_comb begin
        state_d  = state_q;
        wrBank_d = wrBank_q;
        rdBank_d = rdBank_q;
        wrCnt_d  = wrCnt_q;
        rdCnt_d  = rdCnt_q;
        pass_d   = pass_q;
        freeBank = 1'b0;

        if (wrAccept) begin
            if (wrCnt_q == LAST_ADDR) begin
                state_d[wrBank_q] = BANK_FULL;
                wrCnt_d           = '0;
                wrBank_d          = ~wrBank_q;
            end else begin
                state_d[wrBank_q] = BANK_FILLING;
                wrCnt_d           = wrCnt_q + 1'b1;
            end
        end

        if (rdAccept) begin
            state_d[rdBank_q] = BANK_DRAINING;
            if (rdCnt_q == LAST_ADDR) begin
                rdCnt_d = '0;
                if (pass_q == LAST_PASS) begin
                    pass_d            = '0;
                    state_d[rdBank_q] = BANK_FREE;
                    rdBank_d          = ~rdBank_q;
                    freeBank          = 1'b1;
                end else begin
                    pass_d = pass_q + 1'b1;
                end
            end else begin
                rdCnt_d = rdCnt_q + 1'b1;
            end
        end
    end

    // layer_start fires on the rising edge of "read bank is FULL", one cycle after it appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0]   <= BANK_FREE;
            state_q[1]   <= BANK_FREE;
            wrBank_q     <= 1'b0;
            rdBank_q     <= 1'b0;
            wrCnt_q      <= '0;
            rdCnt_q      <= '0;
            pass_q       <= '0;
            rdValid_q    <= 1'b0;
            rdLast_q     <= 1'b0;
            frameDone_q  <= 1'b0;
            layerStart_q <= 1'b0;
            exposed_q    <= 1'b0;
            rdSel_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrBank_q     <= wrBank_d;
            rdBank_q     <= rdBank_d;
            wrCnt_q      <= wrCnt_d;
            rdCnt_q      <= rdCnt_d;
            pass_q       <= pass_d;
            rdValid_q    <= rdAccept;
            rdLast_q     <= freeBank;
            frameDone_q  <= freeBank;
            layerStart_q <= exposedNow && !exposed_q;
            exposed_q    <= exposedNow;
            if (rdAccept) begin
                rdSel_q <= rdBank_q;
            end
        end
    end

    fmap_bank_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wrAccept && !wrBank_q),
        .waddr_i(wrCnt_q),
        .wdata_i(storeWord),
        .re_i   (rdAccept && !rdBank_q),
        .raddr_i(rdCnt_q),
        .rdata_o(bankData0)
    );

    fmap_bank_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (wrAccept && wrBank_q),
        .waddr_i(wrCnt_q),
        .wdata_i(storeWord),
        .re_i   (rdAccept && rdBank_q),
        .raddr_i(rdCnt_q),
        .rdata_o(bankData1)
    );

    assign rd_data     = rdSel_q ? bankData1 : bankData0;
    assign rd_valid    = rdValid_q;
    assign rd_last     = rdLast_q;
    assign frame_done  = frameDone_q;
    assign layer_start = layerStart_q;

endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// Directed bench for fmap_pingpong_buf with FM_SIZE=2, CH=2 (8 words per bank).
// A second instance with PASSES=3 shares the inputs for the multi-pass scenario.
module tb_fmap_pingpong_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrEn;
    logic [31:0] wrData;
    logic        rdEn;

    logic        wr_ready, rd_valid, rd_last, layer_start, frame_done;
    logic [31:0] rd_data;
    logic        wrReady3, rdValid3, rdLast3, layerStart3, frameDone3;
    logic [31:0] rdData3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fmap_pingpong_buf #(.DATA_WIDTH(32), .FM_SIZE(2), .CH(2), .PASSES(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_data(wrData), .wr_ready(wr_ready),
        .rd_en(rdEn), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .layer_start(layer_start), .frame_done(frame_done)
    );

    fmap_pingpong_buf #(.DATA_WIDTH(32), .FM_SIZE(2), .CH(2), .PASSES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wrEn), .wr_data(wrData), .wr_ready(wrReady3),
        .rd_en(rdEn), .rd_data(rdData3), .rd_valid(rdValid3), .rd_last(rdLast3),
        .layer_start(layerStart3), .frame_done(frameDone3)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n  = 1'b0;
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        wrData = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic writeWords(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wrEn   = 1'b1;
            wrData = base + 32'(i);
            tick();
        end
        wrEn = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        wrEn   = 1'b1;
        wrData = 32'hDEAD;
        rdEn   = 1'b1;
        tick();
        total++;
        if ({rd_valid, rd_last, layer_start, frame_done, wr_ready} !== 5'b00001) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b, expected 00001",
                     {rd_valid, rd_last, layer_start, frame_done, wr_ready});
        end
        total++;
        if (rd_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_rd_data: got %h, expected 00000000", rd_data);
        end
        rst_n = 1'b1;
        wrEn  = 1'b0;
        tick();
        total++;
        if ({rd_valid, wr_ready} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL read_when_empty: got valid/ready %b, expected 01", {rd_valid, wr_ready});
        end
        rdEn = 1'b0;
    endtask

    task automatic test_basic();
        int lsCount;
        int fdCount;
        doReset();
        lsCount = 0;
        for (int i = 0; i < 8; i++) begin
            wrEn   = 1'b1;
            wrData = 32'(i + 1);
            tick();
            lsCount += int'(layer_start);
        end
        wrEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lsCount += int'(layer_start);
        end
        total++;
        if (lsCount !== 1) begin
            bad++;
            $display("[TB] FAIL basic_layer_start_count: got %0d, expected 1", lsCount);
        end
        total++;
        if (wr_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL basic_wr_ready_after_fill: got %b, expected 1", wr_ready);
        end
        fdCount = 0;
        for (int k = 0; k < 8; k++) begin
            rdEn = 1'b1;
            tick();
            fdCount += int'(frame_done);
            total++;
            if ({rd_valid, rd_data} !== {1'b1, 32'(k + 1)}) begin
                bad++;
                $display("[TB] FAIL basic_data[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                         k, rd_valid, rd_data, 32'(k + 1));
            end
            total++;
            if ({rd_last, frame_done} !== {k == 7, k == 7}) begin
                bad++;
                $display("[TB] FAIL basic_last[%0d]: got last/done=%b, expected %b",
                         k, {rd_last, frame_done}, {k == 7, k == 7});
            end
        end
        rdEn = 1'b0;
        tick();
        fdCount += int'(frame_done);
        total++;
        if ({rd_valid, rd_data} !== {1'b0, 32'd8}) begin
            bad++;
            $display("[TB] FAIL basic_idle_hold: got valid=%b data=%h, expected valid=0 data=00000008",
                     rd_valid, rd_data);
        end
        total++;
        if (fdCount !== 1) begin
            bad++;
            $display("[TB] FAIL basic_frame_done_count: got %0d, expected 1", fdCount);
        end
    endtask

    task automatic test_full();
        doReset();
        for (int i = 0; i < 16; i++) begin
            wrEn   = 1'b1;
            wrData = 32'(i + 1);
            tick();
            if (i == 7) begin
                total++;
                if (wr_ready !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL full_ready_mid: got %b, expected 1", wr_ready);
                end
            end
        end
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_ready_after_16: got %b, expected 0", wr_ready);
        end
        wrData = 32'd99;
        tick();
        wrEn = 1'b0;
        total++;
        if (wr_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_ready_after_drop: got %b, expected 0", wr_ready);
        end
        for (int k = 0; k < 16; k++) begin
            rdEn = 1'b1;
            tick();
            total++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, (k == 7) || (k == 15), 32'(k + 1)}) begin
                bad++;
                $display("[TB] FAIL full_data[%0d]: got valid=%b last=%b data=%h, expected valid=1 last=%b data=%h",
                         k, rd_valid, rd_last, rd_data, (k == 7) || (k == 15), 32'(k + 1));
            end
        end
        rdEn = 1'b0;
    endtask

    task automatic test_passes();
        doReset();
        writeWords(32'd1, 8);
        tick();
        tick();
        for (int k = 0; k < 24; k++) begin
            rdEn = 1'b1;
            tick();
            total++;
            if ({rdValid3, rdData3} !== {1'b1, 32'((k % 8) + 1)}) begin
                bad++;
                $display("[TB] FAIL passes_data[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                         k, rdValid3, rdData3, 32'((k % 8) + 1));
            end
            total++;
            if ({frameDone3, rdLast3} !== {k == 23, k == 23}) begin
                bad++;
                $display("[TB] FAIL passes_done[%0d]: got done/last=%b, expected %b",
                         k, {frameDone3, rdLast3}, {k == 23, k == 23});
            end
        end
        rdEn = 1'b0;
    endtask

    task automatic test_back_to_back();
        doReset();
        writeWords(32'd1, 8);
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            wrEn   = 1'b1;
            wrData = 32'(11 + k);
            rdEn   = 1'b1;
            tick();
            total++;
            if (rd_data !== 32'(k + 1)) begin
                bad++;
                $display("[TB] FAIL overlap_data[%0d]: got %h, expected %h", k, rd_data, 32'(k + 1));
            end
        end
        wrEn = 1'b0;
        rdEn = 1'b0;
        total++;
        if ({frame_done, rd_last, layer_start, wr_ready} !== 4'b1101) begin
            bad++;
            $display("[TB] FAIL overlap_edge: got done/last/start/ready=%b, expected 1101",
                     {frame_done, rd_last, layer_start, wr_ready});
        end
        tick();
        total++;
        if ({layer_start, frame_done} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL overlap_layer_start: got start/done=%b, expected 10", {layer_start, frame_done});
        end
        tick();
        total++;
        if (layer_start !== 1'b0) begin
            bad++;
            $display("[TB] FAIL overlap_start_pulse: got %b, expected 0", layer_start);
        end
        for (int k = 0; k < 8; k++) begin
            rdEn = 1'b1;
            tick();
            total++;
            if ({rd_valid, rd_data} !== {1'b1, 32'(11 + k)}) begin
                bad++;
                $display("[TB] FAIL overlap_bank1[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                         k, rd_valid, rd_data, 32'(11 + k));
            end
        end
        rdEn = 1'b0;
    endtask

    // Runs straight after test_back_to_back so rd_data holds a non-zero word at reset.
    task automatic test_reset_mid();
        int lsCount;
        writeWords(32'd1, 5);
        rst_n = 1'b0;
        tick();
        total++;
        if ({rd_valid, rd_last, layer_start, frame_done, wr_ready} !== 5'b00001) begin
            bad++;
            $display("[TB] FAIL midreset_flags: got %b, expected 00001",
                     {rd_valid, rd_last, layer_start, frame_done, wr_ready});
        end
        total++;
        if (rd_data !== 32'h0) begin
            bad++;
            $display("[TB] FAIL midreset_rd_data: got %h, expected 00000000", rd_data);
        end
        rst_n   = 1'b1;
        lsCount = 0;
        for (int i = 0; i < 8; i++) begin
            wrEn   = 1'b1;
            wrData = 32'(21 + i);
            tick();
            lsCount += int'(layer_start);
        end
        wrEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lsCount += int'(layer_start);
        end
        total++;
        if (lsCount !== 1) begin
            bad++;
            $display("[TB] FAIL midreset_layer_start: got %0d, expected 1", lsCount);
        end
        for (int k = 0; k < 8; k++) begin
            rdEn = 1'b1;
            tick();
            total++;
            if ({rd_valid, rd_last, rd_data} !== {1'b1, k == 7, 32'(21 + k)}) begin
                bad++;
                $display("[TB] FAIL midreset_data[%0d]: got valid=%b last=%b data=%h, expected valid=1 last=%b data=%h",
                         k, rd_valid, rd_last, rd_data, k == 7, 32'(21 + k));
            end
        end
        rdEn = 1'b0;
    endtask

    task automatic test_relu();
        logic [31:0] expNeg;
`ifdef FMAP_PINGPONG_BUF_RELU_EN
        expNeg = 32'h0000_0000;
`else
        expNeg = 32'hFFFF_FFFE;
`endif
        doReset();
        wrEn   = 1'b1;
        wrData = 32'hFFFF_FFFE;
        tick();
        wrData = 32'h7FFF_FFFF;
        tick();
        writeWords(32'd3, 6);
        tick();
        rdEn = 1'b1;
        tick();
        total++;
        if (rd_data !== expNeg) begin
            bad++;
            $display("[TB] FAIL relu_negative: got %h, expected %h", rd_data, expNeg);
        end
        tick();
        total++;
        if (rd_data !== 32'h7FFF_FFFF) begin
            bad++;
            $display("[TB] FAIL relu_positive: got %h, expected 7fffffff", rd_data);
        end
        for (int k = 2; k < 8; k++) begin
            tick();
        end
        rdEn = 1'b0;
        tick();
    endtask

    initial begin
        rst_n  = 1'b0;
        wrEn   = 1'b0;
        rdEn   = 1'b0;
        wrData = '0;
        test_reset();
        test_basic();
        test_full();
        test_passes();
        test_back_to_back();
        test_reset_mid();
        test_relu();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
